multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
- Sits between the execute stage and the multdiv unit.
- Accepts a mult/div instruction from X, latches operands and destination, issues a single-cycle start pulse to multdiv, and stalls the pipeline until multdiv raises ready.
- Produces one writeback beat: the result to rd, or the exception status code to r30 (rstatus).
- Includes a watchdog so a hung multdiv cannot stall the processor forever.

Parameters:
- TIMEOUT, 100, max WAIT cycles before forced completion with exception.
- RSTATUS_MULT, 4, value written to r30 on mult exception or timeout.
- RSTATUS_DIV, 5, value written to r30 on div exception or timeout.
- RSTATUS_REG, 30, destination register used on exception.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- issue_mult  in  1  X-stage instruction is mul; held high while stalled.
- issue_div  in  1  X-stage instruction is div; held high while stalled.
- opA  in  32  X-stage operand A.
- opB  in  32  X-stage operand B.
- rd  in  5  X-stage destination register.
- md_operandA  out  32  latched operand A to multdiv.
- md_operandB  out  32  latched operand B to multdiv.
- md_ctrl_MULT  out  1  one-cycle mult start pulse.
- md_ctrl_DIV  out  1  one-cycle div start pulse.
- md_result  in  32  multdiv result.
- md_except  in  1  multdiv exception.
- md_ready  in  1  multdiv result ready.
- stall  out  1  freeze PC/F/D/X latches.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- wb_except  out  1  writeback carries an exception.
- wb_timeout  out  1  writeback caused by watchdog.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset_n low at a clock edge) from any state:
  - state to IDLE; latched operands, rd, op type and counter to 0.
  - All registered outputs to 0. No ctrl pulse is emitted.
  - Reset mid-operation abandons the op; any later md_ready is ignored in IDLE.
- States:
  - IDLE -> START on an accepted issue.
  - START -> WAIT unconditionally.
  - WAIT -> DONE on md_ready or on watchdog expiry.
  - DONE -> IDLE unconditionally.
- IDLE:
  - Issue is accepted when issue_mult | issue_div.
  - If both are high, mult wins; div is not issued.
  - On acceptance, latch opA, opB, rd and op type. md_operandA/B hold the latched values until the next acceptance.
- START:
  - Exactly one of md_ctrl_MULT / md_ctrl_DIV is high for this single cycle (registered outputs).
  - md_ready is ignored in START, since it may be stale from the previous op.
- WAIT:
  - Counter starts at 0 and increments each cycle.
  - md_ready high: capture md_result and md_except, go to DONE.
  - Counter reaches TIMEOUT-1 without ready: go to DONE with forced exception and wb_timeout=1.
  - md_ready on the expiry cycle takes priority: normal completion, no timeout.
- DONE (outputs registered, valid exactly this cycle):
  - wb_valid=1.
  - Normal completion: wb_rd=rd, wb_data=md_result, wb_except=0.
  - Exception or timeout: wb_rd=RSTATUS_REG, wb_data=RSTATUS_MULT or RSTATUS_DIV by op type, wb_except=1.
  - All wb_* outputs are 0 in every other cycle.
- stall is combinational: (IDLE & (issue_mult|issue_div)) | START | WAIT.
  - Low in DONE, so the instruction leaves X together with its writeback.
  - Issue inputs seen in DONE belong to the same instruction and are not re-accepted.
- Latency:
  - Issue sampled at edge 0; ctrl pulse in cycle 1; WAIT from cycle 2.
  - md_ready seen in WAIT cycle n gives wb_valid in cycle n+1.
  - Back-to-back ops: next acceptance no earlier than the IDLE cycle after DONE.
- Width rules:
  - Operands and result are passed through unmodified as 32-bit two's complement.
  - The counter is clog2(TIMEOUT)+1 bits wide and saturates; no wrap.

Test Plan:
- Mult path: issue_mult, opA=7, opB=-3, rd=5 -> one md_ctrl_MULT pulse in cycle 1; stall high until DONE; wb_valid with wb_rd=5, wb_data=-21, wb_except=0.
- Div path: issue_div, opA=100, opB=7, rd=9 -> one md_ctrl_DIV pulse; wb_rd=9, wb_data=14.
- Mult overflow: opA=65536, opB=65536 -> wb_rd=30, wb_data=4, wb_except=1. Div by zero: opA=5, opB=0 -> wb_rd=30, wb_data=5, wb_except=1.
- Watchdog: a stub multdiv that never raises ready -> after TIMEOUT WAIT cycles, wb_valid with wb_timeout=1, wb_rd=30, wb_data=4 (mult); then stall low and state back to IDLE.
- Reset mid-WAIT: pull reset_n low for 1 cycle -> all outputs 0 and busy=0 next cycle; a later md_ready produces no wb_valid.
- Sweep plus edge cases:
  - Back-to-back ops over j,k in [-20,20] -> every wb_data equals j*k; exactly one ctrl pulse per op.
  - Both issue lines high -> only md_ctrl_MULT pulses.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller between the execute stage and the multdiv unit: it latches a mult/div
// instruction, pulses start, stalls until ready or watchdog expiry, then emits one writeback beat.
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT      = 100,
    parameter int unsigned RSTATUS_MULT = 4,
    parameter int unsigned RSTATUS_DIV  = 5,
    parameter int unsigned RSTATUS_REG  = 30
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_except,
    input  logic        md_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_except,
    output logic        wb_timeout,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic                mult_q, mult_d, div_q, div_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                wb_except_q, wb_except_d;
    logic                wb_timeout_q, wb_timeout_d;
    logic [DATA_W-1:0]   status_code;

    assign status_code = is_div_q ? DATA_W'(RSTATUS_DIV) : DATA_W'(RSTATUS_MULT);

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_div_q     <= 1'b0;
            rd_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            mult_q       <= 1'b0;
            div_q        <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_except_q  <= 1'b0;
            wb_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_div_q     <= is_div_d;
            rd_q         <= rd_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            mult_q       <= mult_d;
            div_q        <= div_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_except_q  <= wb_except_d;
            wb_timeout_q <= wb_timeout_d;
        end
    end

    // Next-state and next-output logic; pulses and writeback default to 0 every cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_div_d     = is_div_q;
        rd_d         = rd_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        mult_d       = 1'b0;
        div_d        = 1'b0;
        wb_valid_d   = 1'b0;
        wb_rd_d      = '0;
        wb_data_d    = '0;
        wb_except_d  = 1'b0;
        wb_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue_mult || issue_div) begin
                    state_d  = START;
                    is_div_d = !issue_mult;
                    rd_d     = rd;
                    opa_d    = opA;
                    opb_d    = opB;
                    mult_d   = issue_mult;
                    div_d    = !issue_mult;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // Ready on the expiry cycle still counts as a normal completion
                if (md_ready) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    if (md_except) begin
                        wb_rd_d     = REG_W'(RSTATUS_REG);
                        wb_data_d   = status_code;
                        wb_except_d = 1'b1;
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = md_result;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d      = DONE;
                    wb_valid_d   = 1'b1;
                    wb_rd_d      = REG_W'(RSTATUS_REG);
                    wb_data_d    = status_code;
                    wb_except_d  = 1'b1;
                    wb_timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stall drops in DONE so the instruction leaves X with its writeback
    assign stall = ((state_q == IDLE) && (issue_mult || issue_div))
                 || (state_q == START) || (state_q == WAIT);
    assign busy  = (state_q != IDLE);

    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_ctrl_MULT = mult_q;
    assign md_ctrl_DIV  = div_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_except    = wb_except_q;
    assign wb_timeout   = wb_timeout_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Scoreboard bench for multdiv_issue_ctrl: directed ops against a stub multdiv, with a
// negedge monitor that checks every writeback beat, pulse counts and watchdog latency.
module tb_multdiv_issue_ctrl;

    localparam int unsigned TIMEOUT = 100;
    localparam int NORMAL_STALL = 6;
    localparam int TMO_STALL    = TIMEOUT + 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_mult = 1'b0;
    logic        issue_div = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [4:0]  rd = '0;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_except;
    logic        md_ready;
    logic        stall, wb_valid, wb_except, wb_timeout, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_mult(issue_mult), .issue_div(issue_div),
        .opA(opA), .opB(opB), .rd(rd),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_except(md_except), .md_ready(md_ready),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_except(wb_except), .wb_timeout(wb_timeout), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int last_pulse = 0;
    int mult_pulses = 0, div_pulses = 0;
    int exp_mult = 0, exp_div = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Stub multdiv: 4-cycle latency, ready stays high (stale) until the next start pulse
    logic        hang = 1'b0;
    logic        poke = 1'b0;
    logic        pend;
    int          lat_cnt;
    logic        op_div;
    logic signed [31:0] sa, sb;
    longint      prod;

    always @(posedge clock) begin
        if (!reset_n) begin
            md_ready  <= 1'b0;
            md_result <= '0;
            md_except <= 1'b0;
            pend      <= 1'b0;
            lat_cnt   <= 0;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            md_ready <= 1'b0;
            pend     <= !hang;
            lat_cnt  <= 2;
            op_div   <= md_ctrl_DIV && !md_ctrl_MULT;
            sa       <= md_operandA;
            sb       <= md_operandB;
        end else if (poke) begin
            md_ready <= 1'b1;
        end else if (pend) begin
            if (lat_cnt == 0) begin
                pend     <= 1'b0;
                md_ready <= 1'b1;
                if (op_div) begin
                    md_except <= (sb == 0);
                    md_result <= (sb == 0) ? 32'd0 : 32'(sa / sb);
                end else begin
                    prod = longint'(sa) * longint'(sb);
                    md_result <= prod[31:0];
                    md_except <= (prod != longint'($signed(prod[31:0])));
                end
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every writeback beat
    always @(negedge clock) begin
        if (reset_n) begin
            if (md_ctrl_MULT || md_ctrl_DIV) last_pulse = cyc;
            if (md_ctrl_MULT) mult_pulses++;
            if (md_ctrl_DIV) div_pulses++;
            if (md_ctrl_MULT && md_ctrl_DIV) chk("both_pulses", 64'd1, 64'd0);
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_beat", {27'd0, wb_rd, wb_data, wb_except, wb_timeout},
                        {27'd0, e.rd, e.data, e.exc, e.tmo});
                    if (e.lat != 0) chk("wb_latency", 64'(cyc - last_pulse), 64'(e.lat));
                end
            end else begin
                chk("wb_idle_zero", {25'd0, wb_rd, wb_data, wb_except, wb_timeout}, 64'd0);
            end
        end
    end

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    // Drive one instruction, hold it while stalled, check stall length
    task automatic do_op(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input exp_t e,
                         input int exp_stall);
        int n;
        exp_q.push_back(e);
        if (m) exp_mult++;
        else if (d) exp_div++;
        issue_mult = m;
        issue_div  = d;
        opA = a;
        opB = b;
        rd  = r;
        n = 0;
        forever begin
            @(negedge clock);
            if (!stall) break;
            n++;
            if (n > 400) begin
                mismatched++;
                $display("FAIL stall_stuck: stall high for %0d cycles, expected %0d", n, exp_stall);
                finish_run();
                $fatal(1, "stall never released");
            end
        end
        chk("stall_cycles", 64'(n), 64'(exp_stall));
        @(posedge clock);
        #1;
        issue_mult = 1'b0;
        issue_div  = 1'b0;
    endtask

    function automatic exp_t mk(input logic [4:0] r, input logic [31:0] dt,
                                input logic x, input logic t, input int l);
        exp_t e;
        e.rd = r; e.data = dt; e.exc = x; e.tmo = t; e.lat = l;
        return e;
    endfunction

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_ctrl", 64'({md_ctrl_MULT, md_ctrl_DIV}), 64'd0);
        chk("rst_operands", {md_operandA, md_operandB}, 64'd0);
        chk("rst_wb", {25'd0, wb_rd, wb_data, wb_valid, wb_except}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        do_op(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5, mk(5'd5, 32'hFFFF_FFEB, 0, 0, 0), NORMAL_STALL);
        do_op(0, 1, 32'd100, 32'd7, 5'd9, mk(5'd9, 32'd14, 0, 0, 0), NORMAL_STALL);
        do_op(0, 1, 32'hFFFF_FF9C, 32'd7, 5'd12, mk(5'd12, 32'hFFFF_FFF2, 0, 0, 0), NORMAL_STALL);
        do_op(1, 0, 32'd65536, 32'd65536, 5'd6, mk(5'd30, 32'd4, 1, 0, 0), NORMAL_STALL);
        do_op(0, 1, 32'd5, 32'd0, 5'd8, mk(5'd30, 32'd5, 1, 0, 0), NORMAL_STALL);
        do_op(1, 1, 32'd3, 32'd4, 5'd7, mk(5'd7, 32'd12, 0, 0, 0), NORMAL_STALL);

        hang = 1'b1;
        do_op(1, 0, 32'd9, 32'd9, 5'd4, mk(5'd30, 32'd4, 1, 1, TIMEOUT + 1), TMO_STALL);
        chk("tmo_busy_after", 64'(busy), 64'd0);
        do_op(0, 1, 32'd9, 32'd3, 5'd4, mk(5'd30, 32'd5, 1, 1, TIMEOUT + 1), TMO_STALL);

        // Abandon an op mid-WAIT via reset; a later ready must not write back
        issue_mult = 1'b1; opA = 32'd11; opB = 32'd2; rd = 5'd3;
        exp_mult++;
        repeat (5) @(posedge clock);
        #1;
        reset_n = 1'b0;
        issue_mult = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        chk("midrst_outs", {md_operandA, 25'd0, wb_valid, wb_timeout, wb_except,
                            md_ctrl_MULT, md_ctrl_DIV, wb_rd[1:0]}, 64'd0);
        reset_n = 1'b1;
        hang = 1'b0;
        poke = 1'b1;
        @(posedge clock);
        #1;
        poke = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk("midrst_idle", 64'(busy), 64'd0);

        // Stale ready from the poke is still high here and must be ignored in IDLE/START
        do_op(1, 0, 32'd6, 32'd7, 5'd2, mk(5'd2, 32'd42, 0, 0, 0), NORMAL_STALL);

        for (int j = -20; j <= 20; j++) begin
            for (int k = -20; k <= 20; k++) begin
                do_op(1, 0, 32'(j), 32'(k), 5'(j + k + 40),
                      mk(5'(j + k + 40), 32'(j * k), 0, 0, 0), NORMAL_STALL);
            end
        end

        repeat (4) @(posedge clock);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("mult_pulse_count", 64'(mult_pulses), 64'(exp_mult));
        chk("div_pulse_count", 64'(div_pulses), 64'(exp_div));
        finish_run();
        $finish;
    end

endmodule
